// File: rtl/mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// mul_rr_scheduler: round-robin issue of operand pairs from NUM_REQ requesters
// into one shared pipelined multiplier; tagged results return via a FIFO.
// Revision: 1.0
// ============================================================================
module mul_rr_scheduler #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_LEN    = 32,
  parameter  int MUL_LATENCY = 2,
  parameter  int RSP_DEPTH   = 4,
  localparam int ID_W        = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_b,
  output logic [DATA_LEN-1:0]          mul_a,
  output logic [DATA_LEN-1:0]          mul_b,
  input  logic [DATA_LEN-1:0]          mul_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_LEN-1:0]          rsp_data,
  output logic                         busy
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic                 grant_vld;
  logic [ID_W-1:0]      grant_idx;
  logic [DATA_LEN-1:0]  grant_a, grant_b;
  logic                 can_issue, pop, push;
  int                   inflight, off, best_off;

  logic [MUL_LATENCY:0] tag_v_q;
  logic [ID_W-1:0]      tag_id_q [MUL_LATENCY+1];

  logic [ID_W-1:0]      fifo_id_q   [RSP_DEPTH];
  logic [DATA_LEN-1:0]  fifo_data_q [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [DATA_LEN-1:0]  mul_a_q, mul_b_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = tag_v_q[MUL_LATENCY];

  // Count every op already committed to a FIFO slot so a full FIFO is never pushed.
  always_comb begin
    inflight = 0;
    for (int k = 0; k <= MUL_LATENCY; k++) begin
      inflight = inflight + int'(tag_v_q[k]);
    end
    can_issue = (inflight + int'(count_q) - int'(pop)) < RSP_DEPTH;
  end

  always_comb begin
    best_off  = NUM_REQ;
    off       = 0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = (i + NUM_REQ - int'(ptr_q)) % NUM_REQ;
      if (req_valid[i] && (off < best_off)) begin
        best_off  = off;
        grant_idx = ID_W'(i);
      end
    end
    grant_vld = (best_off < NUM_REQ) && can_issue && !reset;
  end

  always_comb begin
    req_ready = '0;
    grant_a   = '0;
    grant_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && (grant_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        grant_a      = req_a[i*DATA_LEN +: DATA_LEN];
        grant_b      = req_b[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      tag_v_q  <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k <= MUL_LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= grant_a;
      mul_b_q     <= grant_b;
      tag_v_q     <= {tag_v_q[MUL_LATENCY-1:0], grant_vld};
      tag_id_q[0] <= grant_idx;
      for (int k = 1; k <= MUL_LATENCY; k++) begin
        tag_id_q[k] <= tag_id_q[k-1];
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]   <= tag_id_q[MUL_LATENCY];
      fifo_data_q[wr_ptr_q] <= mul_result;
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign rsp_id   = rsp_valid ? fifo_id_q[rd_ptr_q]   : '0;
  assign rsp_data = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign busy     = (|tag_v_q) || rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mul_rr_scheduler: directed vectors and sequences for mul_rr_scheduler,
// with a behavioural multiplier pipeline and a response scoreboard.
// Revision: 1.0
// ============================================================================
module tb_mul_rr_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int DATA_LEN    = 32;
  localparam int MUL_LATENCY = 2;
  localparam int RSP_DEPTH   = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*DATA_LEN-1:0] req_a, req_b;
  logic [DATA_LEN-1:0]         mul_a, mul_b, mul_result;
  logic                        rsp_valid, rsp_ready;
  logic [1:0]                  rsp_id;
  logic [DATA_LEN-1:0]         rsp_data;
  logic                        busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mul_rr_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_LEN   (DATA_LEN),
    .MUL_LATENCY(MUL_LATENCY),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_result(mul_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // Behavioural multiplier: MUL_LATENCY register stages after mul_a/mul_b.
  logic [DATA_LEN-1:0] mpipe [MUL_LATENCY];
  always @(posedge clk) begin
    mpipe[0] <= mul_a * mul_b;
    for (int k = 1; k < MUL_LATENCY; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[MUL_LATENCY-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot(input int i);
    return 32'd1 << i;
  endfunction

  typedef struct {
    logic [1:0]  id;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  // Scoreboard: handshakes queue expected products, popped responses are compared.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (dut.tag_v_q[MUL_LATENCY] && dut.count_q == 3'd4 && !(rsp_valid && rsp_ready)) begin
        err_cnt++;
        $display("FAIL fifo_overflow: push into full FIFO at %0t", $time);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
          chk("sb_rsp_data", rsp_data, e.d);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t n;
          logic [31:0] pa, pb;
          pa   = req_a[i*DATA_LEN +: DATA_LEN];
          pb   = req_b[i*DATA_LEN +: DATA_LEN];
          n.id = 2'(i);
          n.d  = pa * pb;
          exp_q.push_back(n);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && busy; i++) tick();
    settle();
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_lost"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  typedef struct {
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs;
    logic [31:0] a_cur;

    vt[0] = '{2'd1, 32'd6,          32'd7,          32'd42};
    vt[1] = '{2'd0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE};
    vt[2] = '{2'd2, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000};
    vt[3] = '{2'd3, 32'd0,          32'h1234,       32'd0};
    vt[4] = '{2'd1, 32'h1234_5678,  32'h10,         32'h2345_6780};
    vt[5] = '{2'd2, 32'd1000,       32'd1000,       32'd1000000};

    reset     = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    settle();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mul_a",     mul_a, 32'd0);
    chk("rst_mul_b",     mul_b, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id), 32'd0);
    chk("rst_rsp_data",  rsp_data, 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    reset     = 1'b0;
    req_valid = '0;
    tick();

    // Single isolated operations: latency, id, product and busy fall.
    for (int v = 0; v < 6; v++) begin
      req_a = '0;
      req_b = '0;
      req_a[vt[v].id*DATA_LEN +: DATA_LEN] = vt[v].a;
      req_b[vt[v].id*DATA_LEN +: DATA_LEN] = vt[v].b;
      req_valid = 4'(onehot(int'(vt[v].id)));
      settle();
      chk("tbl_req_ready", 32'(req_ready), onehot(int'(vt[v].id)));
      tick();
      req_valid = '0;
      settle();
      chk("tbl_mul_a", mul_a, vt[v].a);
      chk("tbl_mul_b", mul_b, vt[v].b);
      tick();
      tick();
      settle();
      chk("tbl_early_rsp", 32'(rsp_valid), 32'd0);
      tick();
      settle();
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("tbl_rsp_id",    32'(rsp_id), 32'(vt[v].id));
      chk("tbl_rsp_data",  rsp_data, vt[v].p);
      chk("tbl_busy_hi",   32'(busy), 32'd1);
      tick();
      settle();
      chk("tbl_busy_lo",   32'(busy), 32'd0);
      chk("tbl_rsp_gone",  32'(rsp_valid), 32'd0);
      tick();
    end

    // Full contention: all four valid, one grant per cycle in ring order.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DATA_LEN +: DATA_LEN] = 32'(i + 3);
      req_b[i*DATA_LEN +: DATA_LEN] = 32'(i + 5);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      settle();
      chk("cont_grant", 32'(req_ready), onehot(k % 4));
      if (k >= 4) begin
        chk("cont_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("cont_rsp_id",    32'(rsp_id), 32'((k - 4) % 4));
      end
      tick();
    end
    drain("cont_drain");

    // Backpressure: credits stop issue after RSP_DEPTH ops, then resume.
    rsp_ready = 1'b0;
    hs        = 0;
    a_cur     = 32'd100;
    for (int c = 0; c < 10; c++) begin
      req_a[DATA_LEN-1:0] = a_cur;
      req_b[DATA_LEN-1:0] = 32'd3;
      req_valid = 4'b0001;
      settle();
      if (req_ready[0]) begin
        hs++;
        a_cur = a_cur + 32'd1;
      end
      tick();
    end
    chk("bp_handshakes", 32'(hs), 32'd4);
    req_a[DATA_LEN-1:0] = a_cur;
    settle();
    chk("bp_stalled", 32'(req_ready), 32'd0);
    chk("bp_held_rsp", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_a[DATA_LEN-1:0] = a_cur;
      settle();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_id",    32'(rsp_id), 32'd0);
      if (req_ready[0]) begin
        hs++;
        a_cur = a_cur + 32'd1;
      end
      tick();
    end
    chk("bp_resume_hs", 32'(hs), 32'd8);
    drain("bp_drain");

    // Fairness: only requesters 0 and 2 contend.
    do_reset();
    req_a[0*DATA_LEN +: DATA_LEN] = 32'd11;
    req_b[0*DATA_LEN +: DATA_LEN] = 32'd13;
    req_a[2*DATA_LEN +: DATA_LEN] = 32'd17;
    req_b[2*DATA_LEN +: DATA_LEN] = 32'd19;
    req_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("fair_grant", 32'(req_ready), onehot((k % 2 == 0) ? 0 : 2));
      tick();
    end
    drain("fair_drain");

    // Reset with three ops in flight: all are discarded.
    req_a[1*DATA_LEN +: DATA_LEN] = 32'd5;
    req_b[1*DATA_LEN +: DATA_LEN] = 32'd9;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("mid_issue", 32'(req_ready), 32'b0010);
      tick();
    end
    reset     = 1'b1;
    req_valid = 4'b1111;
    settle();
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    reset     = 1'b0;
    req_valid = '0;
    settle();
    chk("mid_busy",  32'(busy), 32'd0);
    chk("mid_mul_a", mul_a, 32'd0);
    chk("mid_mul_b", mul_b, 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    req_valid = 4'b1111;
    settle();
    chk("mid_first_grant", 32'(req_ready), 32'b0001);
    tick();
    drain("mid_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_rr_scheduler.md
# mul_rr_scheduler

Round-robin scheduler that shares one fixed-latency pipelined `multiplier` instance between `NUM_REQ` requesters inside the AFU. It accepts operand pairs over per-requester valid/ready ports and issues at most one operation per cycle into the multiplier. It tags each operation through the pipeline and returns results, with requester IDs, through a credit-protected response FIFO. The multiplier is instantiated next to this block on the same `clk`, with no divided clock.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range is 2 or more.
- `DATA_LEN`, default 32: operand and result width.
- `MUL_LATENCY`, default 2: cycles from operands on `mul_a`/`mul_b` to the matching `mul_result`. Legal range is 1 or more.
- `RSP_DEPTH`, default 4: number of response FIFO entries. 1 or more is legal; `MUL_LATENCY+2` or more is required for 1 op/cycle.
- `ID_W`, derived as `max(1, $clog2(NUM_REQ))`: requester ID width.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: per-requester operation valid.
- `req_ready`  out  NUM_REQ: per-requester grant. It is combinational and at most one bit is high.
- `req_a`  in  NUM_REQ*DATA_LEN: operand a; requester i uses `[i*DATA_LEN +: DATA_LEN]`.
- `req_b`  in  NUM_REQ*DATA_LEN: operand b, packed the same way.
- `mul_a`  out  DATA_LEN: registered operand a to the multiplier.
- `mul_b`  out  DATA_LEN: registered operand b to the multiplier.
- `mul_result`  in  DATA_LEN: multiplier product (low DATA_LEN bits).
- `rsp_valid`  out  1: response FIFO head valid.
- `rsp_ready`  in  1: response consumer accept.
- `rsp_id`  out  ID_W: requester index of the head entry.
- `rsp_data`  out  DATA_LEN: product of the head entry.
- `busy`  out  1: high when any operation is in flight or the FIFO is non-empty.

## Operation
- Handshake: requester i transfers when `req_valid[i] && req_ready[i]`. A requester holds `req_a`/`req_b` stable while valid and not granted. `req_ready` depends on `req_valid`; this is intentional.
- Credit rule:
  - `pop = rsp_valid && rsp_ready`.
  - `inflight` = popcount of tag-pipeline valid bits, stages 0..MUL_LATENCY.
  - `can_issue = (inflight + count - pop) < RSP_DEPTH`. This prevents FIFO overflow by construction.
- Arbitration: a round-robin pointer `ptr` is reset to 0.
  - When `can_issue` is high, grant the first i with `req_valid[i]`, searching `ptr, ptr+1, … (mod NUM_REQ)`.
  - After a grant to i, `ptr <= (i+1) mod NUM_REQ`.
  - With no grant, `ptr` holds.
- Issue: on a grant, `mul_a`/`mul_b` load the granted operands at the next edge. In all other cycles they load 0.
- Tag pipeline: stages 0..MUL_LATENCY, each holding {valid, id}.
  - Stage 0 loads {grant, granted id}.
  - Stage k loads stage k-1.
  - Stage 0 is aligned with `mul_a`/`mul_b`; stage MUL_LATENCY is aligned with `mul_result`.
- Write: when stage MUL_LATENCY is valid, {id, `mul_result`} is pushed into the FIFO at the end of that cycle.
- FIFO: RSP_DEPTH entries, in-order, circular read/write pointers, plus `count`.
  - Simultaneous push and pop is allowed at any occupancy, including full and empty.
  - Push into a full FIFO without a pop is illegal and is covered by a bench assertion.
- Arithmetic: the result is the low DATA_LEN bits of the product, unsigned. Overflow wraps silently.
- Reset, applied at any time, including mid-operation:
  - `ptr`=0 and all tag valid bits are cleared.
  - FIFO is emptied.
  - `mul_a`=`mul_b`=0.
  - In-flight operations are discarded and produce no response.
  - While `reset` is high, `req_ready`=0.

## Timing
- Reset values: `req_ready`=0, `mul_a`=0, `mul_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0.
- A handshake in cycle t places operands on `mul_a`/`mul_b` in cycle t+1.
- The product arrives on `mul_result` in cycle t+1+MUL_LATENCY.
- `rsp_valid` rises in cycle t+2+MUL_LATENCY, if the FIFO was empty. Handshake-to-response latency is therefore MUL_LATENCY+2 (4 at defaults).
- Throughput is 1 op/cycle when `RSP_DEPTH >= MUL_LATENCY+2` and `rsp_ready` is held high.
- `busy` is registered-derived and drops the cycle after the last response pops.

## Test plan
- Single op: requester 1 sends a=6, b=7 at cycle t. Required: `rsp_valid` at t+4 with `rsp_id`=1, `rsp_data`=42. `busy` is 0 at t+5 after a pop.
- Full contention: all 4 requesters are valid continuously and `rsp_ready`=1. Required: grants 0,1,2,3,0,… one per cycle; responses arrive in the same order, one per cycle, each with the correct product.
- Backpressure: `rsp_ready`=0 and requester 0 streams.
  - Required: exactly 4 handshakes, then `req_ready`=0.
  - After raising `rsp_ready`, 4 in-order responses follow, issue resumes, and no result is lost.
- Wrap-around arithmetic:
  - a=0xFFFF_FFFF, b=2 gives 0xFFFF_FFFE.
  - a=0x0001_0000, b=0x0001_0000 gives 0x0000_0000.
  - a=0, b=0x1234 gives 0.
- Fairness: requesters 0 and 2 are valid permanently. Required: grants alternate 0,2,0,2; requesters 1 and 3 are never granted.
- Reset mid-flight: issue 3 ops, then assert `reset` for 1 cycle on the next cycle.
  - Required: no `rsp_valid` afterwards, `busy`=0 in the cycle after reset, `mul_a`/`mul_b`=0.
  - With all requesters then valid, the first grant goes to requester 0.
